// File: rtl/seg7_capture_decoder_if.sv
// Bus between a multiplexed common-anode 7-segment display and seg7_capture_decoder.
// master drives the display lines and stream ready; slave is the decoder.
interface seg7_capture_decoder_if #(
   parameter int unsigned DIGITS = 4
);
   localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [6:0]          seg_n;
   logic [DIGITS-1:0]   an_n;
   logic [4*DIGITS-1:0] digit_val;
   logic [DIGITS-1:0]   digit_ok;
   logic                out_valid;
   logic                out_ready;
   logic [3:0]          out_digit;
   logic [IDX_W-1:0]    out_idx;
   logic                ovf;
   logic                err;

   modport master (
      output seg_n, an_n, out_ready,
      input  digit_val, digit_ok, out_valid, out_digit, out_idx, ovf, err
   );

   modport slave (
      input  seg_n, an_n, out_ready,
      output digit_val, digit_ok, out_valid, out_digit, out_idx, ovf, err
   );
endinterface

// File: rtl/seg7_capture_decoder.sv
// Sampling decoder for a multiplexed 7-segment bus: sync, settle, glyph decode, valid/ready stream.
// Optional macro SEG7_CAP_CHANGE_ONLY_EN: push only when a digit's value or validity changes.
module seg7_capture_decoder #(
   parameter int unsigned DIGITS        = 4,
   parameter int unsigned STABLE_CYCLES = 8
) (
   input logic                   clk,
   input logic                   rst,
   seg7_capture_decoder_if.slave bus
);
   localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [6:0]          seg_s1_q, seg_s2_q, seg_prev_q;
   logic [DIGITS-1:0]   an_s1_q, an_s2_q, an_prev_q;
   logic [4*DIGITS-1:0] digit_val_q, digit_val_d;
   logic [DIGITS-1:0]   digit_ok_q, digit_ok_d;
   logic                out_valid_q, out_valid_d;
   logic [3:0]          out_digit_q, out_digit_d;
   logic [IDX_W-1:0]    out_idx_q, out_idx_d;
   logic                ovf_q, ovf_d;
   logic                err_q, err_d;

   logic                changed, qualified, one_low;
   logic [DIGITS-1:0]   an_low;
   logic [IDX_W-1:0]    cap_idx;
   logic                cap_legal;
   logic [3:0]          cap_val;
   logic                push;

   function automatic logic [4:0] glyph_decode(input logic [6:0] seg);
      logic [4:0] r;
      case (seg)
         7'h3F:   r = {1'b1, 4'h0};
         7'h06:   r = {1'b1, 4'h1};
         7'h5B:   r = {1'b1, 4'h2};
         7'h4F:   r = {1'b1, 4'h3};
         7'h66:   r = {1'b1, 4'h4};
         7'h6D:   r = {1'b1, 4'h5};
         7'h7D:   r = {1'b1, 4'h6};
         7'h07:   r = {1'b1, 4'h7};
         7'h7F:   r = {1'b1, 4'h8};
         7'h6F:   r = {1'b1, 4'h9};
         7'h77:   r = {1'b1, 4'hA};
         7'h7C:   r = {1'b1, 4'hB};
         7'h39:   r = {1'b1, 4'hC};
         7'h5E:   r = {1'b1, 4'hD};
         7'h79:   r = {1'b1, 4'hE};
         7'h71:   r = {1'b1, 4'hF};
         default: r = '0;
      endcase
      return r;
   endfunction

   assign an_low    = ~an_s2_q;
   assign one_low   = (an_low != '0) && ((an_low & (an_low - 1'b1)) == '0);
   assign qualified = one_low && (~seg_s2_q != 7'h00);
   assign changed   = (seg_s2_q != seg_prev_q) || (an_s2_q != an_prev_q);

   // The prev register holds the pattern proven stable, so CAPTURE decodes from it.
   always_comb begin
      cap_idx = '0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (!an_prev_q[i]) cap_idx = IDX_W'(i);
      end
      {cap_legal, cap_val} = glyph_decode(~seg_prev_q);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (qualified) begin
               state_d = SETTLE;
               cnt_d   = '0;
            end
         end
         SETTLE: begin
            if (changed) begin
               cnt_d   = '0;
               state_d = qualified ? SETTLE : IDLE;
            end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
               state_d = CAPTURE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         CAPTURE, HOLD: begin
            // A change during CAPTURE must not be lost, so it is handled like one in HOLD.
            if (changed) begin
               cnt_d   = '0;
               state_d = qualified ? SETTLE : IDLE;
            end else begin
               state_d = HOLD;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      digit_val_d = digit_val_q;
      digit_ok_d  = digit_ok_q;
      out_valid_d = out_valid_q;
      out_digit_d = out_digit_q;
      out_idx_d   = out_idx_q;
      ovf_d       = 1'b0;
      err_d       = 1'b0;
      push        = 1'b0;

      if (state_q == CAPTURE) begin
         if (cap_legal) begin
`ifdef SEG7_CAP_CHANGE_ONLY_EN
            push = !digit_ok_q[cap_idx] ||
                   (digit_val_q[{cap_idx, 2'b00} +: 4] != cap_val);
`else
            push = 1'b1;
`endif
            digit_val_d[{cap_idx, 2'b00} +: 4] = cap_val;
            digit_ok_d[cap_idx]                = 1'b1;
         end else begin
            err_d               = 1'b1;
            digit_ok_d[cap_idx] = 1'b0;
         end
      end

      if (push) begin
         out_valid_d = 1'b1;
         out_digit_d = cap_val;
         out_idx_d   = cap_idx;
         ovf_d       = out_valid_q && !bus.out_ready;
      end else if (out_valid_q && bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_s1_q    <= '1;
         seg_s2_q    <= '1;
         seg_prev_q  <= '1;
         an_s1_q     <= '1;
         an_s2_q     <= '1;
         an_prev_q   <= '1;
         state_q     <= IDLE;
         cnt_q       <= '0;
         digit_val_q <= '0;
         digit_ok_q  <= '0;
         out_valid_q <= 1'b0;
         out_digit_q <= '0;
         out_idx_q   <= '0;
         ovf_q       <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         seg_s1_q    <= bus.seg_n;
         seg_s2_q    <= seg_s1_q;
         seg_prev_q  <= seg_s2_q;
         an_s1_q     <= bus.an_n;
         an_s2_q     <= an_s1_q;
         an_prev_q   <= an_s2_q;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         digit_val_q <= digit_val_d;
         digit_ok_q  <= digit_ok_d;
         out_valid_q <= out_valid_d;
         out_digit_q <= out_digit_d;
         out_idx_q   <= out_idx_d;
         ovf_q       <= ovf_d;
         err_q       <= err_d;
      end
   end

   assign bus.digit_val = digit_val_q;
   assign bus.digit_ok  = digit_ok_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_digit = out_digit_q;
   assign bus.out_idx   = out_idx_q;
   assign bus.ovf       = ovf_q;
   assign bus.err       = err_q;
endmodule

// File: tb/tb_seg7_capture_decoder.sv
// Scoreboard bench for seg7_capture_decoder: directed display patterns, queued expected beats.
module tb_seg7_capture_decoder;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   seg7_capture_decoder_if #(.DIGITS(4)) bus ();

   seg7_capture_decoder #(.DIGITS(4), .STABLE_CYCLES(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;
   int beats = 0;
   int err_pulses = 0;
   int ovf_pulses = 0;
   logic [5:0] exp_q[$];
   logic [5:0] exp_e;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int n);
      bus.an_n  = an;
      bus.seg_n = seg;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: one stream beat per negedge where valid && ready.
   always @(negedge clk) begin
      if (bus.err) err_pulses++;
      if (bus.ovf) ovf_pulses++;
      if (bus.out_valid && bus.out_ready) begin
         beats++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL beat_unexpected actual=%0h required=none", {bus.out_idx, bus.out_digit});
         end else begin
            exp_e = exp_q.pop_front();
            if ({bus.out_idx, bus.out_digit} !== exp_e) begin
               errors++;
               $display("FAIL beat_data actual=%0h required=%0h", {bus.out_idx, bus.out_digit}, exp_e);
            end
         end
      end
   end

   logic [6:0] g3[4] = '{7'h77, 7'h7C, 7'h39, 7'h5E};
   logic [3:0] an_v;
   int b0, e0;

   initial begin
      rst           = 1'b1;
      bus.an_n      = '1;
      bus.seg_n     = '1;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_digit_val", bus.digit_val, 0);
      check("rst_digit_ok", bus.digit_ok, 0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_err_ovf", {bus.err, bus.ovf}, 0);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // First capture and its latency: results appear after edge 11.
      bus.an_n  = 4'b1110;
      bus.seg_n = ~7'h5B;
      exp_q.push_back({2'd0, 4'h2});
      repeat (11) @(posedge clk);
      #1;
      check("t2_valid_edge10", bus.out_valid, 0);
      @(posedge clk);
      #1;
      check("t2_valid_edge11", bus.out_valid, 1);
      check("t2_out_digit", bus.out_digit, 4'h2);
      check("t2_out_idx", bus.out_idx, 0);
      check("t2_digit_val", bus.digit_val[3:0], 4'h2);
      check("t2_digit_ok", bus.digit_ok, 4'b0001);
      repeat (3) @(posedge clk);
      #1;
      check("t2_beats", beats, 1);

      // Reset asserted mid-SETTLE clears everything at once.
      bus.an_n  = 4'b1101;
      bus.seg_n = ~7'h06;
      repeat (5) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("t1_digit_val", bus.digit_val, 0);
      check("t1_digit_ok", bus.digit_ok, 0);
      check("t1_out_digit", bus.out_digit, 0);
      check("t1_out_valid", bus.out_valid, 0);
      bus.an_n  = '1;
      bus.seg_n = '1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      drive(4'b1111, 7'h7F, 4);
      check("t1_after_valid", bus.out_valid, 0);

      // Scan digits 0..3 with A, b, C, d.
      b0 = beats;
      for (int i = 0; i < 4; i++) begin
         an_v = 4'b0001 << i;
         exp_q.push_back({2'(i), 4'(10 + i)});
         drive(~an_v, ~g3[i], 20);
      end
      check("t3_digit_val", bus.digit_val, 16'hDCBA);
      check("t3_digit_ok", bus.digit_ok, 4'hF);
      check("t3_beats", beats - b0, 4);
      check("t3_err", err_pulses, 0);
      check("t3_ovf", ovf_pulses, 0);

      // Illegal glyph, then blank on the same digit.
      b0 = beats;
      drive(4'b1011, ~7'h49, 20);
      check("t4_err", err_pulses, 1);
      check("t4_digit_ok", bus.digit_ok, 4'b1011);
      check("t4_digit_val", bus.digit_val, 16'hDCBA);
      drive(4'b1011, 7'h7F, 20);
      check("t4_blank_err", err_pulses, 1);
      check("t4_beats", beats - b0, 0);

      // Overwrite of a held decode.
      b0 = beats;
      bus.out_ready = 1'b0;
      drive(4'b1110, ~7'h6D, 20);
      check("t5_pending", bus.out_valid, 1);
      check("t5_ovf_first", ovf_pulses, 0);
      exp_q.push_back({2'd1, 4'h7});
      drive(4'b1101, ~7'h07, 20);
      check("t5_ovf", ovf_pulses, 1);
      check("t5_out_digit", bus.out_digit, 4'h7);
      check("t5_out_idx", bus.out_idx, 1);
      bus.out_ready = 1'b1;
      drive(4'b1111, 7'h7F, 5);
      check("t5_beats", beats - b0, 1);
      check("t5_valid_done", bus.out_valid, 0);
      check("t5_digit_val", bus.digit_val, 16'hDC75);

      // Unstable pattern and ghosting never capture.
      b0 = beats;
      e0 = err_pulses;
      for (int k = 0; k < 8; k++) begin
         drive(4'b1110, (k % 2 == 0) ? ~7'h3F : ~7'h06, 5);
      end
      drive(4'b1100, ~7'h3F, 20);
      drive(4'b1111, 7'h7F, 5);
      check("t6_nocap_beats", beats - b0, 0);
      check("t6_nocap_err", err_pulses - e0, 0);
      check("t6_nocap_val", bus.digit_val, 16'hDC75);

      // Same value on digit 3 twice.
      b0 = beats;
      exp_q.push_back({2'd3, 4'h8});
      drive(4'b0111, ~7'h7F, 20);
      drive(4'b1111, 7'h7F, 20);
`ifndef SEG7_CAP_CHANGE_ONLY_EN
      exp_q.push_back({2'd3, 4'h8});
`endif
      drive(4'b0111, ~7'h7F, 20);
      drive(4'b1111, 7'h7F, 5);
`ifdef SEG7_CAP_CHANGE_ONLY_EN
      check("t6_repeat_beats", beats - b0, 1);
`else
      check("t6_repeat_beats", beats - b0, 2);
`endif
      check("t6_digit_val", bus.digit_val, 16'h8C75);
      check("end_queue_empty", exp_q.size(), 0);
      check("end_ovf_total", ovf_pulses, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
